neuron_array_lif: RTL and testbench

//  Time-multiplexed array of NUM_NEURONS leaky integrate-and-fire neurons with on-chip membrane state.
//  A command port either adds a synaptic weight into one neuron or runs a decay/fire sweep over all neurons.
//  A sweep processes one neuron per clock and yields a registered spike vector.

---
 rtl/neuron_array_lif_if.sv | 28 ++
 rtl/neuron_array_lif.sv | 163 ++++++++++++++++
 tb/tb_neuron_array_lif.sv | 365 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/neuron_array_lif_if.sv
// Command port bundle for the LIF neuron array.
// The scheduler drives commands; the array answers with cmd_ready.
interface neuron_array_lif_if #(
    parameter int IDX_W       = 4,
    parameter int WEIGHT_SIZE = 8
);
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [1:0]             cmd_op;
    logic [IDX_W-1:0]       cmd_idx;
    logic [WEIGHT_SIZE-1:0] cmd_weight;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_idx,
        output cmd_weight,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_idx,
        input  cmd_weight,
        output cmd_ready
    );
endinterface

// File: rtl/neuron_array_lif.sv
// Time-multiplexed leaky integrate-and-fire neuron array.
// ADD integrates a weight, SWEEP decays/fires one neuron per clock.
module neuron_array_lif #(
    parameter int NUM_NEURONS = 16,
    parameter int IDX_W       = 4,
    parameter int WEIGHT_SIZE = 8,
    parameter int V_MEM_SIZE  = 8,
    parameter int B_SIZE      = 8
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    neuron_array_lif_if.slave      cmd,
    input  logic [B_SIZE-1:0]      beta,
    input  logic [V_MEM_SIZE-1:0]  v_th,
    output logic [NUM_NEURONS-1:0] spikes,
    output logic                   sweep_done,
    input  logic [IDX_W-1:0]       rd_idx,
    output logic [V_MEM_SIZE-1:0]  rd_v_mem
);
    localparam int SUM_W =
        ((WEIGHT_SIZE > V_MEM_SIZE) ? WEIGHT_SIZE : V_MEM_SIZE) + 1;
    localparam int PROD_W = V_MEM_SIZE + B_SIZE;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_NEURONS - 1);
    localparam logic [SUM_W-1:0] V_MAX = SUM_W'({V_MEM_SIZE{1'b1}});

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_SWEEP = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_SWEEP,
        S_DONE
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [V_MEM_SIZE-1:0]  r_v [NUM_NEURONS];
    logic [IDX_W-1:0]       r_idx;
    logic [IDX_W-1:0]       r_cnt;
    logic [WEIGHT_SIZE-1:0] r_weight;
    logic [NUM_NEURONS-1:0] r_stage;
    logic [NUM_NEURONS-1:0] r_spikes;
    logic [NUM_NEURONS-1:0] w_stage_nxt;
    logic [V_MEM_SIZE-1:0]  r_rd;
    logic [V_MEM_SIZE-1:0]  w_rd;
    logic [V_MEM_SIZE-1:0]  w_add_v;
    logic [V_MEM_SIZE-1:0]  w_d;
    logic [SUM_W-1:0]       w_sum;
    logic [PROD_W-1:0]      w_prod;
    logic                   w_acc;
    logic                   w_fire;
    logic                   w_idx_ok;
    logic                   w_last;

    assign cmd.cmd_ready = (r_state == S_IDLE);
    assign w_acc         = cmd.cmd_valid && cmd.cmd_ready;
    assign w_idx_ok      = (int'(r_idx) < NUM_NEURONS);
    assign w_last        = (r_cnt == LAST);

    assign w_sum   = SUM_W'(r_v[r_idx]) + SUM_W'(r_weight);
    assign w_add_v = (w_sum > V_MAX) ? '1 : w_sum[V_MEM_SIZE-1:0];

    // beta < 2^B_SIZE, so the shifted product never exceeds v
    assign w_prod = PROD_W'(r_v[r_cnt]) * PROD_W'(beta);
    assign w_d    = w_prod[PROD_W-1:B_SIZE];
    assign w_fire = (w_d > v_th);

    always_comb begin
        w_stage_nxt        = r_stage;
        w_stage_nxt[r_cnt] = w_fire;
    end

    always_comb begin
        w_rd = '0;
        if (int'(rd_idx) < NUM_NEURONS) begin
            w_rd = r_v[rd_idx];
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_acc && cmd.cmd_op == OP_ADD) begin
                    w_state_nxt = S_ADD;
                end else if (w_acc && cmd.cmd_op == OP_SWEEP) begin
                    w_state_nxt = S_SWEEP;
                end
            end
            S_ADD:   w_state_nxt = S_IDLE;
            S_SWEEP: if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                r_v[i] <= '0;
            end
            r_idx    <= '0;
            r_cnt    <= '0;
            r_weight <= '0;
            r_stage  <= '0;
            r_spikes <= '0;
            r_rd     <= '0;
        end else begin
            r_rd <= w_rd;
            unique case (r_state)
                S_IDLE: begin
                    if (w_acc) begin
                        unique case (cmd.cmd_op)
                            OP_ADD: begin
                                r_idx    <= cmd.cmd_idx;
                                r_weight <= cmd.cmd_weight;
                            end
                            OP_SWEEP: begin
                                r_cnt   <= '0;
                                r_stage <= '0;
                            end
                            OP_CLEAR: begin
                                for (int i = 0; i < NUM_NEURONS; i++) begin
                                    r_v[i] <= '0;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                S_ADD: begin
                    if (w_idx_ok) begin
                        r_v[r_idx] <= w_add_v;
                    end
                end
                S_SWEEP: begin
                    r_v[r_cnt] <= w_fire ? '0 : w_d;
                    r_stage    <= w_stage_nxt;
                    r_cnt      <= r_cnt + 1'b1;
                    // publish together with entry into DONE
                    if (w_last) begin
                        r_spikes <= w_stage_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign spikes     = r_spikes;
    assign sweep_done = (r_state == S_DONE);
    assign rd_v_mem   = r_rd;
endmodule

// File: tb/tb_neuron_array_lif.sv
// Directed self-checking bench for neuron_array_lif.
// Each task covers one scenario with hand-computed expectations.
module tb_neuron_array_lif;
    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_SWEEP = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] OP_NOP   = 2'b11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  beta;
    logic [7:0]  v_th;
    logic [3:0]  rd_idx;
    logic [15:0] spikes;
    logic        sweep_done;
    logic [7:0]  rd_v_mem;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    neuron_array_lif_if cmd_if ();

    neuron_array_lif dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .cmd        (cmd_if),
        .beta       (beta),
        .v_th       (v_th),
        .spikes     (spikes),
        .sweep_done (sweep_done),
        .rd_idx     (rd_idx),
        .rd_v_mem   (rd_v_mem)
    );

    task automatic wait_idle();
        for (int k = 0; k < 50 && !cmd_if.cmd_ready; k++) @(negedge clk);
        if (!cmd_if.cmd_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL idle_timeout cmd_ready=%b required 1",
                     cmd_if.cmd_ready);
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [3:0] idx,
                        input logic [7:0] w);
        @(negedge clk);
        wait_idle();
        cmd_if.cmd_valid  = 1'b1;
        cmd_if.cmd_op     = op;
        cmd_if.cmd_idx    = idx;
        cmd_if.cmd_weight = w;
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = OP_NOP;
        wait_idle();
    endtask

    task automatic read_v(input logic [3:0] i, output logic [7:0] v);
        @(negedge clk);
        rd_idx = i;
        @(negedge clk);
        v = rd_v_mem;
    endtask

    task automatic sweep_obs(output int done_at, output int n_done,
                             output int ready_at, output bit early_chg);
        logic [15:0] sp0;
        done_at = -1; n_done = 0; ready_at = -1; early_chg = 1'b0;
        @(negedge clk);
        wait_idle();
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = OP_SWEEP;
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = OP_NOP;
        sp0 = spikes;
        for (int k = 0; k < 30; k++) begin
            if (sweep_done) begin
                n_done++;
                if (done_at < 0) done_at = k;
            end
            if (cmd_if.cmd_ready && ready_at < 0) ready_at = k;
            if (k < 16 && spikes !== sp0) early_chg = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        logic [7:0] v;
        int bad = 0;
        @(negedge clk);
        n_tests++;
        if (cmd_if.cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready got %b required 1", cmd_if.cmd_ready);
        end
        n_tests++;
        if (spikes !== 16'h0 || sweep_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_spikes got %h/%b required 0000/0",
                     spikes, sweep_done);
        end
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            read_v(4'(i), v);
            if (v !== 8'd0) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL reset_vmem got %0d nonzero required 0", bad);
        end
    endtask

    task automatic test_add_sat();
        logic [7:0] v;
        send(OP_ADD, 4'd3, 8'd200);
        read_v(4'd3, v);
        n_tests++;
        if (v !== 8'd200) begin
            n_fail++;
            $display("FAIL add_first got %0d required 200", v);
        end
        send(OP_ADD, 4'd3, 8'd200);
        read_v(4'd3, v);
        n_tests++;
        if (v !== 8'd255) begin
            n_fail++;
            $display("FAIL add_sat got %0d required 255", v);
        end
        send(OP_ADD, 4'd3, 8'd0);
        read_v(4'd3, v);
        n_tests++;
        if (v !== 8'd255) begin
            n_fail++;
            $display("FAIL add_zero got %0d required 255", v);
        end
        send(OP_ADD, 4'd15, 8'd17);
        send(OP_ADD, 4'd15, 8'd238);
        read_v(4'd15, v);
        n_tests++;
        if (v !== 8'd255) begin
            n_fail++;
            $display("FAIL add_top_idx got %0d required 255", v);
        end
    endtask

    task automatic test_decay();
        logic [7:0] v;
        int d, n, r;
        bit e;
        send(OP_CLEAR, 4'd0, 8'd0);
        beta = 8'd128;
        v_th = 8'd120;
        send(OP_ADD, 4'd5, 8'd200);
        sweep_obs(d, n, r, e);
        read_v(4'd5, v);
        n_tests++;
        if (v !== 8'd100) begin
            n_fail++;
            $display("FAIL decay_half got %0d required 100", v);
        end
        n_tests++;
        if (spikes !== 16'h0 || n != 1) begin
            n_fail++;
            $display("FAIL decay_nofire got %h/%0d required 0000/1",
                     spikes, n);
        end
        v_th = 8'd90;
        sweep_obs(d, n, r, e);
        read_v(4'd5, v);
        n_tests++;
        if (v !== 8'd50 || spikes !== 16'h0) begin
            n_fail++;
            $display("FAIL decay_second got %0d/%h required 50/0000",
                     v, spikes);
        end
    endtask

    task automatic test_fire();
        logic [7:0] v;
        int d, n, r;
        bit e;
        send(OP_CLEAR, 4'd0, 8'd0);
        send(OP_ADD, 4'd2, 8'd250);
        send(OP_ADD, 4'd9, 8'd100);
        beta = 8'd255;
        v_th = 8'd200;
        sweep_obs(d, n, r, e);
        n_tests++;
        if (d != 16 || n != 1) begin
            n_fail++;
            $display("FAIL fire_done got at=%0d cnt=%0d required 16/1",
                     d, n);
        end
        n_tests++;
        if (r != 17) begin
            n_fail++;
            $display("FAIL fire_ready got %0d required 17", r);
        end
        n_tests++;
        if (e) begin
            n_fail++;
            $display("FAIL fire_hold got early_change=1 required 0");
        end
        n_tests++;
        if (spikes !== 16'h0004) begin
            n_fail++;
            $display("FAIL fire_spikes got %h required 0004", spikes);
        end
        read_v(4'd2, v);
        n_tests++;
        if (v !== 8'd0) begin
            n_fail++;
            $display("FAIL fire_v2 got %0d required 0", v);
        end
        read_v(4'd9, v);
        n_tests++;
        if (v !== 8'd99) begin
            n_fail++;
            $display("FAIL fire_v9 got %0d required 99", v);
        end
    endtask

    task automatic test_clear();
        logic [7:0] v;
        send(OP_CLEAR, 4'd0, 8'd0);
        n_tests++;
        if (spikes !== 16'h0004) begin
            n_fail++;
            $display("FAIL clear_spikes got %h required 0004", spikes);
        end
        read_v(4'd9, v);
        n_tests++;
        if (v !== 8'd0) begin
            n_fail++;
            $display("FAIL clear_v9 got %0d required 0", v);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] v;
        int d, n, r;
        int pulses = 0;
        bit e;
        send(OP_ADD, 4'd2, 8'd250);
        beta = 8'd255;
        v_th = 8'd200;
        @(negedge clk);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = OP_SWEEP;
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = OP_NOP;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        #1;
        n_tests++;
        if (cmd_if.cmd_ready !== 1'b1 || spikes !== 16'h0) begin
            n_fail++;
            $display("FAIL midrst_async got %b/%h required 1/0000",
                     cmd_if.cmd_ready, spikes);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 25; k++) begin
            if (sweep_done) pulses++;
            @(negedge clk);
        end
        n_tests++;
        if (pulses != 0) begin
            n_fail++;
            $display("FAIL midrst_nodone got %0d pulses required 0",
                     pulses);
        end
        read_v(4'd2, v);
        n_tests++;
        if (v !== 8'd0) begin
            n_fail++;
            $display("FAIL midrst_v2 got %0d required 0", v);
        end
        send(OP_ADD, 4'd2, 8'd250);
        sweep_obs(d, n, r, e);
        n_tests++;
        if (d != 16 || spikes !== 16'h0004) begin
            n_fail++;
            $display("FAIL midrst_rerun got at=%0d spk=%h required 16/0004",
                     d, spikes);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] v;
        int acc_k = -1;
        int done_k = -1;
        send(OP_ADD, 4'd6, 8'd5);
        beta = 8'd255;
        v_th = 8'd200;
        @(negedge clk);
        wait_idle();
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = OP_SWEEP;
        @(negedge clk);
        cmd_if.cmd_op     = OP_ADD;
        cmd_if.cmd_idx    = 4'd4;
        cmd_if.cmd_weight = 8'd30;
        for (int k = 0; k < 30; k++) begin
            if (cmd_if.cmd_ready) begin
                acc_k = k;
                break;
            end
            if (sweep_done) done_k = k;
            @(negedge clk);
        end
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = OP_NOP;
        wait_idle();
        n_tests++;
        if (done_k != 16 || acc_k != 17) begin
            n_fail++;
            $display("FAIL b2b_timing got done=%0d acc=%0d required 16/17",
                     done_k, acc_k);
        end
        read_v(4'd4, v);
        n_tests++;
        if (v !== 8'd30) begin
            n_fail++;
            $display("FAIL b2b_once got %0d required 30", v);
        end
        read_v(4'd6, v);
        n_tests++;
        if (v !== 8'd4) begin
            n_fail++;
            $display("FAIL b2b_decay got %0d required 4", v);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cmd_if.cmd_valid  = 1'b0;
        cmd_if.cmd_op     = OP_NOP;
        cmd_if.cmd_idx    = 4'd0;
        cmd_if.cmd_weight = 8'd0;
        beta   = 8'd0;
        v_th   = 8'd0;
        rd_idx = 4'd0;
        test_reset();
        test_add_sat();
        test_decay();
        test_fire();
        test_clear();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
